// File: rtl/cache_mem_l2_assoc.sv
// N-way set-associative dual-port L2 cache array with true-LRU replacement and write-back victims.
// Both ports are resolved in one cycle: port 2 operates on the set state left by port 1.
module cache_mem_l2_assoc #(
    parameter int BLOCK_SIZE  = 128,
    parameter int TAG_SIZE    = 7,
    parameter int IDX_SIZE    = 8,
    parameter int WORD_SIZE   = 2,
    parameter int OFFSET_SIZE = 2,
    parameter int WAYS        = 2,
    localparam int AW = TAG_SIZE + IDX_SIZE + WORD_SIZE + OFFSET_SIZE,
    localparam int BE = BLOCK_SIZE / 8,
    localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int BA = TAG_SIZE + IDX_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  read_p1_i,
    input  logic                  read_p2_i,
    input  logic                  write_p1_i,
    input  logic                  write_p2_i,
    input  logic [AW-1:0]         addr_p1_i,
    input  logic [AW-1:0]         addr_p2_i,
    input  logic [BLOCK_SIZE-1:0] data_block_p1_i,
    input  logic [BLOCK_SIZE-1:0] data_block_p2_i,
    input  logic [BE-1:0]         byte_enable_p1_i,
    input  logic [BE-1:0]         byte_enable_p2_i,
    output logic [BLOCK_SIZE-1:0] data_block_p1_o,
    output logic [BLOCK_SIZE-1:0] data_block_p2_o,
    output logic                  hit_p1_o,
    output logic                  hit_p2_o,
    output logic                  valid_p1_o,
    output logic                  valid_p2_o,
    output logic                  evict_valid_p1_o,
    output logic                  evict_valid_p2_o,
    output logic [BA-1:0]         evict_addr_p1_o,
    output logic [BA-1:0]         evict_addr_p2_o,
    output logic [BLOCK_SIZE-1:0] evict_data_p1_o,
    output logic [BLOCK_SIZE-1:0] evict_data_p2_o
);

    localparam int SETS = 2 ** IDX_SIZE;
    localparam int LO   = WORD_SIZE + OFFSET_SIZE;

    typedef struct packed {
        logic [WAYS-1:0]                 vld;
        logic [WAYS-1:0]                 dty;
        logic [WAYS-1:0][TAG_SIZE-1:0]   tag;
        logic [WAYS-1:0][LW-1:0]         age;
        logic [WAYS-1:0][BLOCK_SIZE-1:0] data;
    } set_t;

    typedef struct packed {
        set_t                  s;
        logic                  rvalid;
        logic                  hit;
        logic [BLOCK_SIZE-1:0] rdata;
        logic                  ev;
        logic [BA-1:0]         ev_addr;
        logic [BLOCK_SIZE-1:0] ev_data;
    } res_t;

    typedef struct packed {
        logic                  valid;
        logic                  hit;
        logic [BLOCK_SIZE-1:0] data;
        logic                  ev;
        logic [BA-1:0]         ev_addr;
        logic [BLOCK_SIZE-1:0] ev_data;
    } out_t;

    set_t mem_q [SETS];
    out_t out1_q, out2_q, out1_d, out2_d;
    set_t s1, s2;
    res_t r1, r2;

    logic [TAG_SIZE-1:0] tag1, tag2;
    logic [IDX_SIZE-1:0] idx1, idx2;
    logic                unused_addr_bits;

    assign tag1 = addr_p1_i[AW-1 -: TAG_SIZE];
    assign tag2 = addr_p2_i[AW-1 -: TAG_SIZE];
    assign idx1 = addr_p1_i[LO +: IDX_SIZE];
    assign idx2 = addr_p2_i[LO +: IDX_SIZE];
    assign unused_addr_bits = ^{addr_p1_i[LO-1:0], addr_p2_i[LO-1:0]};

    // Make way k MRU; ways younger than its old age shift one step older.
    function automatic set_t touch(input set_t s, input int k);
        set_t t;
        t = s;
        for (int w = 0; w < WAYS; w++) begin
            if (w == k)
                t.age[w] = '0;
            else if (s.age[w] < s.age[k])
                t.age[w] = s.age[w] + LW'(1);
        end
        return t;
    endfunction

    function automatic res_t access(input set_t s, input logic rd, input logic wr,
                                    input logic [TAG_SIZE-1:0] tg, input logic [IDX_SIZE-1:0] ix,
                                    input logic [BLOCK_SIZE-1:0] din, input logic [BE-1:0] be);
        res_t r;
        int k;
        logic hit;
        logic [BLOCK_SIZE-1:0] mask;
        r = '0;
        r.s = s;
        hit = 1'b0;
        k = 0;
        mask = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (s.vld[w] && s.tag[w] == tg) begin
                hit = 1'b1;
                k = w;
            end
        end
        for (int b = 0; b < BE; b++)
            mask[8*b +: 8] = {8{be[b]}};
        if (wr) begin
            if (hit) begin
                r.s.data[k] = (s.data[k] & ~mask) | (din & mask);
                r.s.dty[k]  = 1'b1;
                r.s = touch(r.s, k);
            end else begin
                // LRU way by default, overridden by the lowest-index invalid way.
                for (int w = WAYS - 1; w >= 0; w--)
                    if (s.age[w] == LW'(WAYS - 1)) k = w;
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!s.vld[w]) k = w;
                r.ev      = s.vld[k] & s.dty[k];
                r.ev_addr = {s.tag[k], ix};
                r.ev_data = s.data[k];
                r.s.data[k] = din & mask;
                r.s.tag[k]  = tg;
                r.s.vld[k]  = 1'b1;
                r.s.dty[k]  = 1'b1;
                r.s = touch(r.s, k);
            end
        end else if (rd) begin
            r.rvalid = 1'b1;
            if (hit) begin
                r.hit   = 1'b1;
                r.rdata = s.data[k];
                r.s = touch(r.s, k);
            end
        end
        return r;
    endfunction

    function automatic out_t to_out(input res_t r);
        out_t o;
        o = '0;
        o.valid = r.rvalid;
        o.hit   = r.hit;
        o.data  = r.hit ? r.rdata : '0;
        o.ev    = r.ev;
        if (r.ev) begin
            o.ev_addr = r.ev_addr;
            o.ev_data = r.ev_data;
        end
        return o;
    endfunction

    always_comb begin
        s1 = mem_q[idx1];
        r1 = access(s1, read_p1_i, write_p1_i, tag1, idx1, data_block_p1_i, byte_enable_p1_i);
        s2 = (idx2 == idx1) ? r1.s : mem_q[idx2];
        r2 = access(s2, read_p2_i, write_p2_i, tag2, idx2, data_block_p2_i, byte_enable_p2_i);
        out1_d = to_out(r1);
        out2_d = to_out(r2);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SETS; i++) begin
                mem_q[i].vld <= '0;
                mem_q[i].dty <= '0;
                for (int w = 0; w < WAYS; w++)
                    mem_q[i].age[w] <= LW'(w);
            end
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            // Port 2 result already folds in port 1 when both hit the same set.
            if (read_p1_i || write_p1_i) mem_q[idx1] <= r1.s;
            if (read_p2_i || write_p2_i) mem_q[idx2] <= r2.s;
            out1_q <= out1_d;
            out2_q <= out2_d;
        end
    end

    assign valid_p1_o       = out1_q.valid;
    assign hit_p1_o         = out1_q.hit;
    assign data_block_p1_o  = out1_q.data;
    assign evict_valid_p1_o = out1_q.ev;
    assign evict_addr_p1_o  = out1_q.ev_addr;
    assign evict_data_p1_o  = out1_q.ev_data;
    assign valid_p2_o       = out2_q.valid;
    assign hit_p2_o         = out2_q.hit;
    assign data_block_p2_o  = out2_q.data;
    assign evict_valid_p2_o = out2_q.ev;
    assign evict_addr_p2_o  = out2_q.ev_addr;
    assign evict_data_p2_o  = out2_q.ev_data;

endmodule

// File: doc/cache_mem_l2_assoc.md
Name: cache_mem_l2_assoc

Overview:
Parametrised, N-way set-associative, dual-port L2 cache memory with true-LRU replacement, per-line dirty tracking and write-back victim output on each port. It succeeds the direct-mapped dual-port L2 array and keeps its port naming and block/byte-enable conventions. Port 1 serves the data cache and the memory path; port 2 serves the instruction cache.

Parameters:
BLOCK_SIZE, 128, line width in bits (multiple of 8)
TAG_SIZE, 7, tag field width
IDX_SIZE, 8, set index width (2^IDX_SIZE sets)
WORD_SIZE, 2, word-select field width (ignored by this block)
OFFSET_SIZE, 2, byte-offset field width (ignored by this block)
WAYS, 2, associativity; power of 2, range 1..8
Derived: AW = TAG_SIZE+IDX_SIZE+WORD_SIZE+OFFSET_SIZE; BE = BLOCK_SIZE/8; LW = log2(WAYS), minimum 1.

Ports:
clk_i  in  1  single clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-low
read_p1_i / read_p2_i  in  1  read request, per port
write_p1_i / write_p2_i  in  1  write request, per port
addr_p1_i / addr_p2_i  in  AW  address {tag, idx, word, offset}
data_block_p1_i / data_block_p2_i  in  BLOCK_SIZE  write data
byte_enable_p1_i / byte_enable_p2_i  in  BE  byte b selects bits [8b+7:8b]
data_block_p1_o / data_block_p2_o  out  BLOCK_SIZE  read data
hit_p1_o / hit_p2_o  out  1  read hit
valid_p1_o / valid_p2_o  out  1  read response valid (1-cycle pulse)
evict_valid_p1_o / evict_valid_p2_o  out  1  dirty victim written back (1-cycle pulse)
evict_addr_p1_o / evict_addr_p2_o  out  TAG_SIZE+IDX_SIZE  victim block address {tag, idx}
evict_data_p1_o / evict_data_p2_o  out  BLOCK_SIZE  victim line data

Behaviour:
- Storage: 2^IDX_SIZE sets x WAYS lines. Each line holds valid, dirty, tag and data. Each set holds a LW-bit age per way; age 0 is the most recently used (MRU), age WAYS-1 is the least recently used (LRU).
- Reset (rst_i=0 at an edge): clear all valid and dirty bits; set age[w]=w in every set; drive all outputs to 0. Reset overrides any request in the same cycle, including a request in flight. Data and tag arrays are not cleared.
- Read, latency 1: a request sampled at edge N produces registered outputs after edge N. valid_o=1 for exactly that cycle.
  - Hit means any valid way matches the tag. On hit: hit_o=1, data_o = full line, LRU updated.
  - On miss: hit_o=0, data_o=0, no allocation, no LRU change.
  - Word and offset fields are ignored.
- Write, write-allocate:
  - Hit: merge enabled bytes into the line, set dirty=1, update LRU.
  - Miss: the victim is the lowest-index invalid way; if none, the way with age WAYS-1.
  - If the victim is valid and dirty: one cycle after the request, evict_valid_o=1 with the victim's {tag, idx} and its pre-overwrite data.
  - The victim is then filled: enabled bytes from data_in, disabled bytes 0, valid=1, dirty=1, new tag, and the way becomes MRU.
- LRU update on an access to way k with old age a: age[k]=0; every way with age < a increments; other ages are unchanged.
- Read and write on the same port in the same cycle: the write is performed, the read is dropped (valid_o=0).
- Both ports in the same cycle are processed sequentially, port 1 then port 2:
  - Port 2 sees port 1's updates: tag, data, dirty and LRU.
  - Same block written by both ports: port-2 bytes win on overlap.
  - Port-2 read of a block written by port 1: returns the merged data.
  - Two misses to the same set choose distinct victims; port 2 picks after port 1's fill.
- Evict outputs stay 0 on cycles without a dirty eviction. Data outputs are 0 when valid_o=0.
- WAYS=1 degenerates to direct-mapped: the victim is always way 0.

Test Plan (WAYS=2, idx/tag values in decimal):
1. Reset, release, then read p1 idx1 tag5 -> next cycle valid_p1_o=1, hit_p1_o=0, data 0. No evict pulses.
2. Same cycle: write p1 idx1 tag5 data 15, write p2 idx1 tag6 data 20, BE=16'hFFFF -> tag5 in way0, tag6 in way1. Then a dual read (p1 tag5, p2 tag6) -> hit both, data 15 and 20, evict outputs 0.
3. After scenario 2, read tag6, then write idx1 tag9 data 10 -> evict_valid_p1_o=1, evict_addr={5,1}, evict_data=15. Subsequent reads: tag9 -> 10 hit, tag5 -> miss, tag6 -> 20 hit.
4. Partial write hit, tag6 data 128'hAB with BE=16'h0001 -> read returns 128'hAB (byte0 replaced). Write BE=16'h0002 data 128'hCD00 -> read 128'hCDAB.
5. Same cycle: p1 write idx0 tag5 data 40, p2 read idx0 tag5 -> hit_p2_o=1, data 40. Same-cycle read+write on p1 -> valid_p1_o=0.
6. Assert rst_i=0 during a write to idx0 tag1 and hold it through the write's sampling edge -> after release, read idx0 tag1 misses and no evict pulse is ever seen.
